// File: rtl/axi_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_if : request/return bundle shared by the I and D refill
//                     paths and the downstream AXI read port.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              i_rd_req;
  logic              i_rd_type;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              i_rd_rdy;
  logic              i_ret_valid;
  logic              i_ret_half;
  logic [DATA_W-1:0] i_ret_data;

  logic              d_rd_req;
  logic              d_rd_type;
  logic [ADDR_W-1:0] d_rd_addr;
  logic              d_rd_rdy;
  logic              d_ret_valid;
  logic              d_ret_half;
  logic [DATA_W-1:0] d_ret_data;

  logic              axi_rd_req;
  logic              axi_rd_type;
  logic [ADDR_W-1:0] axi_rd_addr;
  logic              axi_rd_rdy;
  logic              axi_ret_valid;
  logic              axi_ret_half;
  logic [DATA_W-1:0] axi_ret_data;

  // Arbiter view
  modport master (
    input  i_rd_req, i_rd_type, i_rd_addr,
    output i_rd_rdy, i_ret_valid, i_ret_half, i_ret_data,
    input  d_rd_req, d_rd_type, d_rd_addr,
    output d_rd_rdy, d_ret_valid, d_ret_half, d_ret_data,
    output axi_rd_req, axi_rd_type, axi_rd_addr,
    input  axi_rd_rdy, axi_ret_valid, axi_ret_half, axi_ret_data
  );

  // Requester / downstream view
  modport slave (
    output i_rd_req, i_rd_type, i_rd_addr,
    input  i_rd_rdy, i_ret_valid, i_ret_half, i_ret_data,
    output d_rd_req, d_rd_type, d_rd_addr,
    input  d_rd_rdy, d_ret_valid, d_ret_half, d_ret_data,
    input  axi_rd_req, axi_rd_type, axi_rd_addr,
    output axi_rd_rdy, axi_ret_valid, axi_ret_half, axi_ret_data
  );
endinterface

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter : round-robin I/D refill arbiter onto one AXI read port,
//                  one outstanding read, with grant/contention counters.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_rd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int CNT_W   = 32,
  parameter bit D_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  axi_rd_arbiter_if.master    bus,
  output logic [CNT_W-1:0]    cnt_i_grant,
  output logic [CNT_W-1:0]    cnt_d_grant,
  output logic [CNT_W-1:0]    cnt_conflict
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t r_state, w_state_n;
  logic   r_owner, w_owner_n;   // 0 = I, 1 = D
  logic   r_last,  w_last_n;

  logic              w_sel;
  logic              w_req;
  logic              w_accept;
  logic              w_conflict;
  logic              w_ret_en;
  logic [ADDR_W-1:0] w_fwd_addr;
  logic [DATA_W-1:0] w_ret_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= D_FIRST;
      r_last       <= ~D_FIRST;
      cnt_i_grant  <= '0;
      cnt_d_grant  <= '0;
      cnt_conflict <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_last  <= w_last_n;
      if (w_accept && !w_sel) cnt_i_grant <= cnt_i_grant + 1'b1;
      if (w_accept &&  w_sel) cnt_d_grant <= cnt_d_grant + 1'b1;
      if (w_conflict)         cnt_conflict <= cnt_conflict + 1'b1;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_owner_n  = r_owner;
    w_last_n   = r_last;
    w_sel      = r_owner;
    w_req      = 1'b0;
    w_accept   = 1'b0;
    w_conflict = 1'b0;
    w_ret_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first
        w_sel      = (bus.i_rd_req && bus.d_rd_req) ? ~r_last : bus.d_rd_req;
        w_req      = bus.i_rd_req | bus.d_rd_req;
        w_accept   = w_req & bus.axi_rd_rdy;
        w_conflict = bus.i_rd_req & bus.d_rd_req;
        if (w_req) begin
          w_owner_n = w_sel;
          w_state_n = bus.axi_rd_rdy ? S_BUSY : S_HOLD;
        end
        if (w_accept) w_last_n = w_sel;
      end
      S_HOLD: begin
        w_req      = r_owner ? bus.d_rd_req : bus.i_rd_req;
        w_accept   = w_req & bus.axi_rd_rdy;
        w_conflict = r_owner ? bus.i_rd_req : bus.d_rd_req;
        if (w_accept) begin
          w_last_n  = r_owner;
          w_state_n = S_BUSY;
        end
      end
      S_BUSY: begin
        w_ret_en   = 1'b1;
        w_conflict = r_owner ? bus.i_rd_req : bus.d_rd_req;
        if (bus.axi_ret_valid) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_fwd_addr = w_sel ? bus.d_rd_addr : bus.i_rd_addr;
  assign w_ret_data = w_ret_en ? bus.axi_ret_data : '0;

  assign bus.axi_rd_req  = w_req;
  assign bus.axi_rd_type = w_sel ? bus.d_rd_type : bus.i_rd_type;
  assign bus.axi_rd_addr = w_fwd_addr;

  assign bus.i_rd_rdy = w_accept & ~w_sel;
  assign bus.d_rd_rdy = w_accept &  w_sel;

  // Returns outside BUSY are protocol errors and are simply dropped
  assign bus.i_ret_valid = w_ret_en & ~r_owner & bus.axi_ret_valid;
  assign bus.i_ret_half  = w_ret_en & ~r_owner & bus.axi_ret_half;
  assign bus.i_ret_data  = r_owner ? '0 : w_ret_data;
  assign bus.d_ret_valid = w_ret_en &  r_owner & bus.axi_ret_valid;
  assign bus.d_ret_half  = w_ret_en &  r_owner & bus.axi_ret_half;
  assign bus.d_ret_data  = r_owner ? w_ret_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter : directed checks of grant order, hold locking, return
//                     routing, spurious returns and mid-transaction reset.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] cnt_i_grant, cnt_d_grant, cnt_conflict;
  int checks = 0;
  int errors = 0;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cnt_i_grant  (cnt_i_grant),
    .cnt_d_grant  (cnt_d_grant),
    .cnt_conflict (cnt_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; settle() gives comb paths time
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = '0;
    bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = '0;
    bus.axi_rd_rdy = 0; bus.axi_ret_valid = 0; bus.axi_ret_half = 0;
    bus.axi_ret_data = '0;
  endtask

  task automatic chk_cnt(input string tag, input int ig, input int dg, input int cf);
    chk({tag, "_cnt_i"}, cnt_i_grant, ig);
    chk({tag, "_cnt_d"}, cnt_d_grant, dg);
    chk({tag, "_cnt_conf"}, cnt_conflict, cf);
  endtask

  initial begin
    clear_inputs();
    tick(); tick();
    settle();
    chk("rst_i_rdy", bus.i_rd_rdy, 0);
    chk("rst_d_rdy", bus.d_rd_rdy, 0);
    chk("rst_axi_req", bus.axi_rd_req, 0);
    chk("rst_i_ret", {bus.i_ret_valid, bus.i_ret_half}, 0);
    chk("rst_d_ret", {bus.d_ret_valid, bus.d_ret_half}, 0);
    chk_cnt("rst", 0, 0, 0);
    reset = 0;

    // Single I cached read, accepted the same cycle
    bus.i_rd_req = 1; bus.i_rd_type = 1; bus.i_rd_addr = 32'h1fc0_0000; bus.axi_rd_rdy = 1;
    settle();
    chk("t1_axi_req", bus.axi_rd_req, 1);
    chk("t1_axi_addr", bus.axi_rd_addr, 32'h1fc0_0000);
    chk("t1_axi_type", bus.axi_rd_type, 1);
    chk("t1_i_rdy", bus.i_rd_rdy, 1);
    chk("t1_d_rdy", bus.d_rd_rdy, 0);
    tick();
    clear_inputs();
    bus.axi_ret_half = 1; bus.axi_ret_data = 256'hA5A5_0001;
    settle();
    chk("t1_busy_req", bus.axi_rd_req, 0);
    chk("t1_i_half", bus.i_ret_half, 1);
    chk("t1_i_valid_early", bus.i_ret_valid, 0);
    chk("t1_i_data_half", bus.i_ret_data, 256'hA5A5_0001);
    chk("t1_d_data_half", bus.d_ret_data, 0);
    tick();
    bus.axi_ret_half = 0; bus.axi_ret_valid = 1; bus.axi_ret_data = {128'h1234, 128'h5678};
    settle();
    chk("t1_i_valid", bus.i_ret_valid, 1);
    chk("t1_i_data", bus.i_ret_data, {128'h1234, 128'h5678});
    chk("t1_d_valid", {bus.d_ret_valid, bus.d_ret_half}, 0);
    tick();
    clear_inputs();
    settle();
    chk_cnt("t1", 1, 0, 0);

    // Fresh reset: both request, D wins first, then I, then D again
    reset = 1; tick(); reset = 0;
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h0000_1100; bus.i_rd_type = 1;
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_2200; bus.d_rd_type = 1;
    bus.axi_rd_rdy = 1;
    settle();
    chk("t2_first_d_rdy", bus.d_rd_rdy, 1);
    chk("t2_first_i_rdy", bus.i_rd_rdy, 0);
    chk("t2_first_addr", bus.axi_rd_addr, 32'h0000_2200);
    tick();
    bus.d_rd_req = 0; bus.axi_ret_valid = 1; bus.axi_ret_data = 256'hD0;
    settle();
    chk("t2_d_ret", bus.d_ret_valid, 1);
    chk("t2_i_ret_quiet", bus.i_ret_valid, 0);
    chk("t2_busy_i_rdy", bus.i_rd_rdy, 0);
    tick();
    bus.axi_ret_valid = 0;
    settle();
    chk("t2_second_i_rdy", bus.i_rd_rdy, 1);
    chk("t2_second_addr", bus.axi_rd_addr, 32'h0000_1100);
    tick();
    bus.d_rd_req = 1; bus.axi_ret_valid = 1;
    settle();
    chk("t2_i_ret", bus.i_ret_valid, 1);
    chk("t2_d_rdy_busy", bus.d_rd_rdy, 0);
    tick();
    bus.axi_ret_valid = 0;
    settle();
    chk("t2_third_d_rdy", bus.d_rd_rdy, 1);
    chk("t2_third_i_rdy", bus.i_rd_rdy, 0);
    tick();
    bus.i_rd_req = 0; bus.d_rd_req = 0; bus.axi_rd_rdy = 0; bus.axi_ret_valid = 1;
    tick();
    clear_inputs();
    settle();
    chk_cnt("t2", 1, 2, 4);

    // D held off by axi_rd_rdy for 3 cycles; I joins in cycle 2
    bus.d_rd_req = 1; bus.d_rd_type = 1; bus.d_rd_addr = 32'h0000_D000;
    settle();
    chk("t3_c1_addr", bus.axi_rd_addr, 32'h0000_D000);
    chk("t3_c1_d_rdy", bus.d_rd_rdy, 0);
    tick();
    bus.i_rd_req = 1; bus.i_rd_type = 1; bus.i_rd_addr = 32'h0000_1000;
    settle();
    chk("t3_c2_addr", bus.axi_rd_addr, 32'h0000_D000);
    chk("t3_c2_req", bus.axi_rd_req, 1);
    chk("t3_c2_i_rdy", bus.i_rd_rdy, 0);
    tick();
    settle();
    chk("t3_c3_addr", bus.axi_rd_addr, 32'h0000_D000);
    tick();
    bus.axi_rd_rdy = 1;
    settle();
    chk("t3_c4_d_rdy", bus.d_rd_rdy, 1);
    chk("t3_c4_i_rdy", bus.i_rd_rdy, 0);
    chk("t3_c4_addr", bus.axi_rd_addr, 32'h0000_D000);
    tick();
    bus.d_rd_req = 0; bus.axi_ret_valid = 1;
    settle();
    chk("t3_d_ret", bus.d_ret_valid, 1);
    tick();
    bus.axi_ret_valid = 0;
    settle();
    chk("t3_i_rdy", bus.i_rd_rdy, 1);
    chk("t3_i_addr", bus.axi_rd_addr, 32'h0000_1000);
    tick();
    bus.i_rd_req = 0; bus.axi_ret_valid = 1;
    tick();
    clear_inputs();
    settle();
    chk_cnt("t3", 2, 3, 8);

    // Uncached D read, then I forwarded only the cycle after the return
    bus.d_rd_req = 1; bus.d_rd_type = 0; bus.d_rd_addr = 32'hbfaf_8000; bus.axi_rd_rdy = 1;
    settle();
    chk("t4_type", bus.axi_rd_type, 0);
    chk("t4_addr", bus.axi_rd_addr, 32'hbfaf_8000);
    chk("t4_d_rdy", bus.d_rd_rdy, 1);
    tick();
    bus.d_rd_req = 0; bus.i_rd_req = 1; bus.i_rd_addr = 32'h0000_4000;
    bus.axi_ret_valid = 1; bus.axi_ret_data = 256'hC0FFEE;
    settle();
    chk("t4_d_valid", bus.d_ret_valid, 1);
    chk("t4_d_data", bus.d_ret_data, 256'hC0FFEE);
    chk("t4_d_half", bus.d_ret_half, 0);
    chk("t4_no_bypass", bus.axi_rd_req, 0);
    tick();
    bus.axi_ret_valid = 0;
    settle();
    chk("t4_next_req", bus.axi_rd_req, 1);
    chk("t4_next_i_rdy", bus.i_rd_rdy, 1);
    tick();
    bus.i_rd_req = 0; bus.axi_ret_valid = 1;
    tick();
    clear_inputs();
    settle();
    chk_cnt("t4", 3, 4, 9);

    // Spurious return in IDLE is dropped
    bus.axi_ret_valid = 1; bus.axi_ret_half = 1; bus.axi_ret_data = 256'hDEAD;
    settle();
    chk("t5_i_ret", {bus.i_ret_valid, bus.i_ret_half}, 0);
    chk("t5_d_ret", {bus.d_ret_valid, bus.d_ret_half}, 0);
    chk("t5_i_data", bus.i_ret_data, 0);
    chk("t5_d_data", bus.d_ret_data, 0);
    tick();
    clear_inputs();
    settle();
    chk_cnt("t5", 3, 4, 9);
    bus.i_rd_req = 1; bus.axi_rd_rdy = 1;
    settle();
    chk("t5_still_idle", bus.i_rd_rdy, 1);
    tick();
    bus.i_rd_req = 0; bus.axi_rd_rdy = 0; bus.axi_ret_valid = 1;
    tick();
    clear_inputs();

    // Reset while BUSY, then a stale return
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_5000; bus.axi_rd_rdy = 1;
    tick();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    bus.axi_ret_valid = 1; bus.axi_ret_data = 256'hBAD;
    settle();
    chk("t6_d_ret", {bus.d_ret_valid, bus.d_ret_half}, 0);
    chk("t6_i_ret", {bus.i_ret_valid, bus.i_ret_half}, 0);
    chk("t6_d_data", bus.d_ret_data, 0);
    chk_cnt("t6", 0, 0, 0);
    tick();
    clear_inputs();
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h0000_6000; bus.axi_rd_rdy = 1;
    settle();
    chk("t6_i_rdy", bus.i_rd_rdy, 1);
    chk("t6_i_addr", bus.axi_rd_addr, 32'h0000_6000);
    tick();
    clear_inputs();
    settle();
    chk_cnt("t6_after", 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read-request/return interface between the instruction-cache refill path (requester I) and the data-cache refill path (requester D; the D side normally connects through the data-side prefetch buffer).
- Round-robin arbitration with at most one outstanding read.
- Routes return data/valid/half to the owning requester.
- Keeps 32-bit performance counters for grants and contention.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 256, return data width (two 128-bit halves).
- CNT_W, 32, performance counter width.
- D_FIRST, 1, requester that wins the first arbitration after reset (1 = D, 0 = I).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_rd_req  in  1  I read request; held until i_rd_rdy
- i_rd_type  in  1  1 = cached line (two halves), 0 = uncached single
- i_rd_addr  in  ADDR_W  I request address
- i_rd_rdy  out  1  I request accepted this cycle
- i_ret_valid  out  1  final return beat for I
- i_ret_half  out  1  first-half return pulse for I
- i_ret_data  out  DATA_W  return data for I
- d_rd_req / d_rd_type / d_rd_addr / d_rd_rdy / d_ret_valid / d_ret_half / d_ret_data  same as I, for D
- axi_rd_req  out  1  downstream request
- axi_rd_type  out  1  forwarded type
- axi_rd_addr  out  ADDR_W  forwarded address
- axi_rd_rdy  in  1  downstream accepts request
- axi_ret_valid  in  1  final return beat
- axi_ret_half  in  1  first-half pulse (cached reads only)
- axi_ret_data  in  DATA_W  return data
- cnt_i_grant  out  CNT_W  accepted I requests
- cnt_d_grant  out  CNT_W  accepted D requests
- cnt_conflict  out  CNT_W  cycles where a requester waits while the other owns the bus

Behaviour:
- States: IDLE, HOLD, BUSY. Registers: owner (0 = I, 1 = D), last (last accepted owner).
- Reset: state = IDLE; owner = D_FIRST; last = !D_FIRST; all counters 0.
- Outputs at reset: all rdy/ret outputs 0; axi_rd_req 0.
- IDLE, winner selection:
  - Only one req: that requester wins.
  - Both req: the requester not equal to last wins.
- IDLE, forwarding: winner's req/type/addr drive axi_rd_* combinationally in the same cycle (zero-latency forward).
- IDLE, acceptance:
  - axi_rd_rdy = 1: winner's rdy = 1, owner <= winner, last <= winner, state <= BUSY.
  - axi_rd_rdy = 0: owner <= winner, state <= HOLD.
- HOLD: grant is locked.
  - Only the owner's req/type/addr are forwarded, even if the other requester asserts req.
  - On axi_rd_rdy: owner's rdy = 1, last <= owner, state <= BUSY.
- BUSY:
  - axi_rd_req = 0; both rdy = 0.
  - axi_ret_valid, axi_ret_half and axi_ret_data are routed to the owner only; the other side's ret_valid/ret_half = 0 and ret_data = 0.
  - On axi_ret_valid: state <= IDLE.
  - axi_ret_half never ends the transaction.
- Back-to-back: the return cycle ends BUSY, so a new request is forwarded at the earliest in the following cycle (IDLE). No ret-to-req bypass.
- Non-owner rdy is always 0. rdy is never asserted without axi_rd_rdy in the same cycle.
- Requesters must hold req/type/addr stable until rdy. Behaviour when a requester drops req in HOLD is undefined (not checked).
- axi_ret_valid/half in IDLE or HOLD is a protocol error: ignored, no output pulses, state unchanged.
- Counters:
  - cnt_i_grant / cnt_d_grant: +1 on each accepted request of that requester.
  - cnt_conflict: +1 on each cycle the non-owner has req = 1 in HOLD or BUSY, or the loser has req = 1 in IDLE.
  - All counters wrap modulo 2^CNT_W, with no saturation.
- reset mid-transaction:
  - Returns to IDLE and clears counters.
  - Any in-flight return arriving after reset is dropped per the protocol-error rule.

Test Plan:
- Single I cached read, addr 0x1fc0_0000, axi_rd_rdy = 1 same cycle -> i_rd_rdy = 1 that cycle; i_ret_half then i_ret_valid routed with data; d_ret_* stay 0; cnt_i_grant = 1.
- Both req in the first cycle after reset, D_FIRST = 1 -> D granted first. After its ret_valid, I granted next. Then both req again -> D. Grant order D, I, D; cnt_conflict counts every waiting cycle.
- D req with axi_rd_rdy low for 3 cycles, I raising req in cycle 2 -> state HOLD, axi_rd_addr stays D's address all 3 cycles; d_rd_rdy pulses when rdy rises; I served afterwards.
- Uncached D read (type 0, addr 0xbfaf_8000) -> axi_rd_type = 0 forwarded; single d_ret_valid ends BUSY; next request is forwarded in the following cycle.
- Spurious axi_ret_valid in IDLE -> no ret pulse on either side, state and counters unchanged.
- reset asserted while BUSY, then axi_ret_valid arrives -> outputs 0, state IDLE, counters 0; a fresh I request is then granted normally.
